// File: rtl/onehot_demux_stream_pkg.sv
// Shared definitions for the one-hot streaming demultiplexer.
//   SEL_MAX_W         : widest select the is_onehot helper accepts
//   DROPCNT_WIDTH_DEF : default drop-counter width
//   DROPCNT_MAX       : saturation value of the default-width drop counter
//   is_onehot()       : true when exactly one bit of the (zero-extended) select is set
package demux_pkg;

    localparam int SEL_MAX_W         = 32;
    localparam int DROPCNT_WIDTH_DEF = 8;
    localparam logic [DROPCNT_WIDTH_DEF-1:0] DROPCNT_MAX = {DROPCNT_WIDTH_DEF{1'b1}};

    // Callers zero-extend narrower selects, so one function covers every width.
    // Clearing the lowest set bit leaves zero only for a single-bit value.
    function automatic logic is_onehot(input logic [SEL_MAX_W-1:0] v);
        return (v != {SEL_MAX_W{1'b0}}) &&
               ((v & (v - {{(SEL_MAX_W-1){1'b0}}, 1'b1})) == {SEL_MAX_W{1'b0}});
    endfunction

endpackage

// File: rtl/onehot_demux_stream_lane.sv
// One-entry output register slice for a single demux lane.
//   clk, rst_n : clock and asynchronous active-low reset
//   load       : capture ld_data this cycle (top only asserts it when can_accept)
//   ld_data    : beat data to capture
//   out_valid  : slice holds a beat
//   out_ready  : downstream consumer accepts the held beat
//   out_data   : held beat; keeps its last value after the beat drains
//   can_accept : slice is empty or drains this cycle, so a load is safe
module demux_lane
    import demux_pkg::*;
#(
    parameter int DATAWIDTH = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 load,
    input  logic [DATAWIDTH-1:0] ld_data,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [DATAWIDTH-1:0] out_data,
    output logic                 can_accept
);

    logic                 valid_r;
    logic [DATAWIDTH-1:0] data_r;

    assign can_accept = ~valid_r | out_ready;
    assign out_valid  = valid_r;
    assign out_data   = data_r;

    // Slice state: a load wins over a drain, giving back-to-back delivery without a bubble.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_r <= 1'b0;
            data_r  <= {DATAWIDTH{1'b0}};
        end else if (load) begin
            valid_r <= 1'b1;
            data_r  <= ld_data;
        end else if (valid_r && out_ready) begin
            valid_r <= 1'b0;
            data_r  <= data_r;
        end else begin
            valid_r <= valid_r;
            data_r  <= data_r;
        end
    end

endmodule

// File: rtl/onehot_demux_stream.sv
// Streaming one-hot demultiplexer: steers each input beat to the lane named by sel.
//   clk, rst_n : clock and asynchronous active-low reset
//   in_valid   : input beat valid
//   in_ready   : input beat accepted when in_valid && in_ready (combinational)
//   din, sel   : beat data and its one-hot lane select
//   out_valid  : per-lane beat held
//   out_ready  : per-lane consumer accept
//   dout       : packed lane data, lane i at dout[i*DATAWIDTH +: DATAWIDTH]
//   drop_cnt   : saturating count of beats dropped for an illegal select
//   sel_err    : sticky flag, set by the first dropped beat
module onehot_demux_stream
    import demux_pkg::*;
#(
    parameter int DATAWIDTH     = 4,
    parameter int SELECT_WIDTH  = 4,
    parameter int DROPCNT_WIDTH = DROPCNT_WIDTH_DEF
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic                              in_valid,
    output logic                              in_ready,
    input  logic [DATAWIDTH-1:0]              din,
    input  logic [SELECT_WIDTH-1:0]           sel,
    output logic [SELECT_WIDTH-1:0]           out_valid,
    input  logic [SELECT_WIDTH-1:0]           out_ready,
    output logic [DATAWIDTH*SELECT_WIDTH-1:0] dout,
    output logic [DROPCNT_WIDTH-1:0]          drop_cnt,
    output logic                              sel_err
);

    localparam logic [DROPCNT_WIDTH-1:0] CNT_MAX = {DROPCNT_WIDTH{1'b1}};
    localparam logic [DROPCNT_WIDTH-1:0] CNT_ONE = DROPCNT_WIDTH'(1);

    logic [SEL_MAX_W-1:0]     sel_ext_s;
    logic                     sel_ok_s;
    logic                     acc_s;
    logic                     drop_s;
    logic [SELECT_WIDTH-1:0]  load_s;
    logic [SELECT_WIDTH-1:0]  can_accept_s;
    logic [DROPCNT_WIDTH-1:0] drop_cnt_r;
    logic                     sel_err_r;

    // Zero-extend the select to the helper's fixed width.
    always_comb begin
        sel_ext_s                     = {SEL_MAX_W{1'b0}};
        sel_ext_s[SELECT_WIDTH-1:0]   = sel;
    end

    assign sel_ok_s = is_onehot(sel_ext_s);

    // Illegal selects are always accepted so they can be dropped; a legal one
    // waits only on its own lane, never on in_valid.
    assign in_ready = ~sel_ok_s | (|(sel & can_accept_s));
    assign acc_s    = in_valid & in_ready;
    assign drop_s   = acc_s & ~sel_ok_s;
    assign load_s   = {SELECT_WIDTH{acc_s & sel_ok_s}} & sel;

    genvar gi;
    generate
        for (gi = 0; gi < SELECT_WIDTH; gi++) begin : g_lane
            demux_lane #(
                .DATAWIDTH (DATAWIDTH)
            ) u_lane (
                .clk        (clk),
                .rst_n      (rst_n),
                .load       (load_s[gi]),
                .ld_data    (din),
                .out_valid  (out_valid[gi]),
                .out_ready  (out_ready[gi]),
                .out_data   (dout[gi*DATAWIDTH +: DATAWIDTH]),
                .can_accept (can_accept_s[gi])
            );
        end
    endgenerate

    // Saturating drop counter and sticky error flag for illegal-select beats.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            drop_cnt_r <= {DROPCNT_WIDTH{1'b0}};
            sel_err_r  <= 1'b0;
        end else if (drop_s) begin
            sel_err_r <= 1'b1;
            if (drop_cnt_r != CNT_MAX) begin
                drop_cnt_r <= drop_cnt_r + CNT_ONE;
            end else begin
                drop_cnt_r <= drop_cnt_r;
            end
        end else begin
            drop_cnt_r <= drop_cnt_r;
            sel_err_r  <= sel_err_r;
        end
    end

    assign drop_cnt = drop_cnt_r;
    assign sel_err  = sel_err_r;

endmodule

// File: tb/tb_onehot_demux_stream.sv
`timescale 1ns/1ps
module tb_onehot_demux_stream;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [3:0]  din;
    logic [3:0]  sel;
    logic [3:0]  out_valid;
    logic [3:0]  out_ready;
    logic [15:0] dout;
    logic [7:0]  drop_cnt;
    logic        sel_err;

    int checks   = 0;
    int failures = 0;
    int last_wait;
    int model_drops = 0;
    bit rand_ready = 1'b0;
    logic [3:0] exp_q [4][$];

    onehot_demux_stream #(
        .DATAWIDTH     (4),
        .SELECT_WIDTH  (4),
        .DROPCNT_WIDTH (8)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .din       (din),
        .sel       (sel),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .dout      (dout),
        .drop_cnt  (drop_cnt),
        .sel_err   (sel_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: record each accepted beat in its lane's FIFO, or count a drop.
    always @(negedge clk) begin
        if (rst_n && in_valid && in_ready) begin
            if ($countones(sel) == 1) begin
                for (int i = 0; i < 4; i++) if (sel[i]) exp_q[i].push_back(din);
            end else if (model_drops < 255) begin
                model_drops++;
            end
        end
    end

    // Monitor: every completed output handshake must deliver the oldest expected beat.
    always @(negedge clk) begin
        if (rst_n) begin
            for (int i = 0; i < 4; i++) begin
                if (out_valid[i] && out_ready[i]) begin
                    if (exp_q[i].size() == 0) begin
                        checks++;
                        failures++;
                        $display("FAIL lane%0d_spurious: got beat %0h, expected none", i, dout[i*4 +: 4]);
                    end else begin
                        chk($sformatf("lane%0d_data", i), 32'(dout[i*4 +: 4]), 32'(exp_q[i].pop_front()));
                    end
                end
            end
        end
    end

    // Random consumer back-pressure during the traffic phase.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (rand_ready) out_ready = 4'($urandom);
        end
    end

    initial begin
        #3ms;
        $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    // Hold a beat until accepted; called and returns just after a rising edge.
    task automatic send(input logic [3:0] d, input logic [3:0] s);
        in_valid  = 1'b1;
        din       = d;
        sel       = s;
        last_wait = 0;
        forever begin
            @(negedge clk);
            if (in_ready) break;
            last_wait++;
            if (last_wait > 200) begin
                checks++;
                failures++;
                $display("FAIL send_timeout: in_ready stuck 0 for sel %b", s);
                break;
            end
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic do_reset();
        #2;
        rst_n = 1'b0;
        #1;
        chk("rst_out_valid", 32'(out_valid), 32'h0);
        chk("rst_dout", 32'(dout), 32'h0);
        chk("rst_drop_cnt", 32'(drop_cnt), 32'h0);
        chk("rst_sel_err", 32'(sel_err), 32'h0);
        for (int i = 0; i < 4; i++) exp_q[i].delete();
        model_drops = 0;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        logic [3:0] s;
        logic [3:0] letters;
        rst_n = 1'b0; in_valid = 1'b0; din = 4'h0; sel = 4'h0; out_ready = 4'h0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // 1: reset mid-stream with lanes 0 and 2 full
        send(4'hD, 4'b0001);
        send(4'h9, 4'b0100);
        chk("t1_full", 32'(out_valid), 32'h5);
        do_reset();
        sel = 4'b0001;
        #1;
        chk("t1_ready_after_reset", 32'(in_ready), 32'h1);

        // 2: one beat per lane, consumers always ready
        out_ready = 4'b1111;
        for (int i = 0; i < 4; i++) begin
            letters = 4'hD - 4'(i);
            s = 4'b0001 << i;
            send(letters, s);
            chk("t2_no_stall", 32'(last_wait), 32'h0);
            chk("t2_pulse", 32'(out_valid), 32'(s));
        end
        idle(1);
        chk("t2_drained", 32'(out_valid), 32'h0);
        chk("t2_dout", 32'(dout), 32'hABCD);

        // 3: stall on lane 0 while lane 2 still accepts
        out_ready = 4'b0000;
        send(4'hD, 4'b0001);
        in_valid = 1'b1; din = 4'hC; sel = 4'b0001;
        @(negedge clk);
        chk("t3_stall_ready", 32'(in_ready), 32'h0);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        send(4'h9, 4'b0100);
        chk("t3_other_lane_wait", 32'(last_wait), 32'h0);
        chk("t3_valid", 32'(out_valid), 32'h5);
        out_ready = 4'b0001;
        send(4'hC, 4'b0001);
        chk("t3_release_wait", 32'(last_wait), 32'h0);
        chk("t3_valid_after", 32'(out_valid), 32'h5);
        chk("t3_lane0", 32'(dout[3:0]), 32'hC);
        out_ready = 4'b1111;
        idle(2);

        // 4: simultaneous drain and load on lane 1
        out_ready = 4'b0000;
        send(4'h5, 4'b0010);
        out_ready = 4'b0010;
        send(4'h7, 4'b0010);
        chk("t4_wait", 32'(last_wait), 32'h0);
        chk("t4_valid", 32'(out_valid), 32'h2);
        chk("t4_lane1", 32'(dout[7:4]), 32'h7);
        out_ready = 4'b1111;
        idle(2);

        // 5: illegal selects dropped, counter saturates
        send(4'h3, 4'b0000);
        chk("t5_zero_wait", 32'(last_wait), 32'h0);
        send(4'h6, 4'b0110);
        chk("t5_multi_wait", 32'(last_wait), 32'h0);
        chk("t5_no_lane", 32'(out_valid), 32'h0);
        chk("t5_drop2", 32'(drop_cnt), 32'h2);
        chk("t5_sel_err", 32'(sel_err), 32'h1);
        for (int n = 0; n < 256; n++) begin
            do s = 4'($urandom); while ($countones(s) == 1);
            send(4'($urandom), s);
        end
        chk("t5_saturate", 32'(drop_cnt), 32'd255);
        chk("t5_model_drops", 32'(drop_cnt), 32'(model_drops));

        // 6: random traffic with random back-pressure
        do_reset();
        rand_ready = 1'b1;
        for (int n = 0; n < 10000; n++) begin
            if ($urandom_range(63) == 0) begin
                do s = 4'($urandom); while ($countones(s) == 1);
            end else begin
                s = 4'b0001 << $urandom_range(3);
            end
            send(4'($urandom), s);
            if ($urandom_range(7) == 0) idle(1);
        end
        rand_ready = 1'b0;
        out_ready  = 4'b1111;
        idle(3);
        chk("t6_drained", 32'(out_valid), 32'h0);
        for (int i = 0; i < 4; i++) chk($sformatf("t6_lane%0d_left", i), 32'(exp_q[i].size()), 32'h0);
        chk("t6_drop_cnt", 32'(drop_cnt), 32'(model_drops));
        chk("t6_sel_err", 32'(sel_err), 32'(model_drops != 0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/onehot_demux_stream.md
Name: onehot_demux_stream

Overview:
- Streaming one-hot demultiplexer: the inverse of the team's one-hot `mux`. It takes a single valid/ready input stream and steers each beat to exactly one of SELECT_WIDTH output lanes.
- Each lane has a one-entry output register, so downstream consumers stall independently.
- Beats with an illegal select (zero-hot or multi-hot) are consumed and dropped, and a counter records each drop.
- Sits between a single producer and SELECT_WIDTH parallel consumers, e.g. a fan-out stage in front of per-channel datapaths.

Parameters:
- DATAWIDTH, 4: bits per beat and per lane.
- SELECT_WIDTH, 4: number of output lanes; width of the one-hot select.
- DROPCNT_WIDTH, 8: width of the saturating illegal-select drop counter.

Ports:
- clk  input  1  single clock, rising edge.
- rst_n  input  1  reset, asynchronous assert, active-low.
- in_valid  input  1  input beat valid.
- in_ready  output  1  input beat accepted when in_valid && in_ready.
- din  input  DATAWIDTH  input beat data.
- sel  input  SELECT_WIDTH  one-hot lane select, sampled with the beat.
- out_valid  output  SELECT_WIDTH  bit i = lane i holds a beat.
- out_ready  input  SELECT_WIDTH  bit i = lane i consumer accepts.
- dout  output  DATAWIDTH*SELECT_WIDTH  packed lane data; lane i is dout[i*DATAWIDTH +: DATAWIDTH], same packing as the mux din.
- drop_cnt  output  DROPCNT_WIDTH  count of dropped illegal-select beats, saturating.
- sel_err  output  1  sticky; set on the first dropped beat.

Behaviour:
- Clock and reset: one clock, clk. Reset rst_n is asynchronous and active-low. Deassertion is synchronized externally.
- Reset values: out_valid=0, dout=0, drop_cnt=0, sel_err=0. Reset mid-operation discards all held beats immediately and undelivered data is lost. in_ready follows its combinational rule; with all lanes empty it evaluates to 1.
- Select legality: sel_ok = sel is exactly one-hot.
- in_ready is combinational:
  - = 1 when !sel_ok.
  - Otherwise = OR over i of sel[i] & (!out_valid[i] | out_ready[i]).
  - in_ready depends on sel and out_ready, but never on in_valid.
- Accept rule: acc = in_valid && in_ready.
- Lane i load: acc && sel_ok && sel[i].
  - Next edge: out_valid[i]=1 and the lane i dout slice = din.
  - Latency is 1 cycle from the accept edge to out_valid.
- Lane i drain: out_valid[i] && out_ready[i] with no load to lane i in the same cycle. Next edge: out_valid[i]=0.
- Simultaneous load and drain on the same lane: the held beat is delivered and the new beat loads. out_valid[i] stays 1 and the data is replaced. This gives full throughput of 1 beat/cycle per lane.
- Unselected lanes: state is unchanged by any input beat.
- dout slice behaviour:
  - Holds its last value while out_valid[i]=0; it is not cleared.
  - Is stable while out_valid[i]=1 and out_ready[i]=0.
- Illegal select: acc && !sel_ok.
  - The beat is dropped and no lane changes.
  - drop_cnt increments by 1, saturating at 2^DROPCNT_WIDTH-1.
  - sel_err is set and stays set until reset.
- Back-pressure: a full, stalled selected lane deasserts in_ready. Other lanes keep draining. The input does not switch to a different sel while stalled; sel is held with in_valid.
- Stability: out_valid[i] never drops without a completed handshake, except on reset.
- Width: all lane slices are exactly DATAWIDTH, with no sign extension or truncation.

Decomposition:
- Package demux_pkg:
  - function is_onehot(logic [SELECT_WIDTH-1:0]) (parameterised via a class or generic width argument).
  - localparam for DROPCNT max.
- Sub-module demux_lane:
  - One-entry register slice per lane, parameterised by DATAWIDTH.
  - Ports: clk, rst_n, load, ld_data, out_valid, out_ready, out_data, can_accept.
  - Instantiated SELECT_WIDTH times in a generate loop.
- Top level holds the sel decode, in_ready reduction, drop counter and sel_err.

Test Plan (DATAWIDTH=4, SELECT_WIDTH=4):
1. Reset with rst_n=0 mid-stream (lanes 0 and 2 full) -> out_valid=4'b0000 and dout=16'h0000 within the same cycle. After release, in_ready=1 with all lanes empty.
2. out_ready=4'b1111; send din=D,C,B,A with sel=0001,0010,0100,1000 on consecutive cycles -> each out_valid bit pulses 1 cycle after its accept; final dout=16'hABCD; in_ready=1 throughout.
3. out_ready=0000; send D to sel=0001, then C to sel=0001 -> second beat stalls with in_ready=0. Then send 9 to sel=0100 -> accepted, out_valid=0101. Raise out_ready[0] -> D delivered, C loads next edge.
4. Lane 1 full and out_ready[1]=1; in the same cycle send 7 to sel=0010 -> out_valid[1] stays 1 and the lane 1 slice becomes 7 next edge, no bubble.
5. Send sel=0000 and then sel=0110, both with in_valid=1 -> in_ready=1, no lane changes, drop_cnt=2, sel_err=1. Send 256 more illegal beats -> drop_cnt saturates at 255.
6. Random traffic, 10k beats with random out_ready -> scoreboard per lane shows in-order delivery, no loss or duplication of legal beats, and drop_cnt equal to the illegal-beat count.
